// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small TX FIFO.
// Stores to TXDATA queue bytes, which are sent LSB-first as 8N1 frames
// with a programmable bit period of BAUD_DIV+1 clocks.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit (8E1).
module mmio_uart_tx #(
  parameter int                        ADDR_BUS_WIDTH   = 32,
  parameter int                        DATA_BUS_WIDTH   = 32,
  parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR        = 32'h00004000,
  parameter int                        FIFO_DEPTH       = 4,
  parameter logic [15:0]               DEFAULT_BAUD_DIV = 16'd3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_BUS_WIDTH-1:0] addr,
  input  logic [DATA_BUS_WIDTH-1:0] write_data,
  input  logic                      write_en,
  output logic [DATA_BUS_WIDTH-1:0] read_data,
  output logic                      tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

`ifdef UART_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr, r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_baud;

  state_t        r_state, w_nextState;
  logic          r_tx, w_nextTx;
  logic [15:0]   r_bcnt, w_nextBcnt;
  logic [2:0]    r_bidx, w_nextBidx;
  logic [7:0]    r_shift, w_nextShift;

  logic          w_hit, w_push, w_statusWr, w_baudWr;
  logic [1:0]    w_off;
  logic          w_full, w_empty, w_pop, w_accept, w_boundary;
  logic [7:0]    w_head;
  logic [3:0]    w_cnt4;
  logic          w_unused;

  assign w_hit      = (addr[ADDR_BUS_WIDTH-1:4] == BASE_ADDR[ADDR_BUS_WIDTH-1:4]);
  assign w_off      = addr[3:2];
  assign w_push     = write_en && w_hit && (w_off == 2'd0);
  assign w_statusWr = write_en && w_hit && (w_off == 2'd1);
  assign w_baudWr   = write_en && w_hit && (w_off == 2'd2);

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_head     = r_mem[r_rdPtr];
  assign w_accept   = w_push && (!w_full || w_pop);
  assign w_boundary = (r_bcnt == 16'd0);
  assign w_cnt4     = 4'(r_count);
  assign tx         = r_tx;
  assign w_unused   = ^{addr[1:0], write_data[DATA_BUS_WIDTH-1:16]};

  // FIFO storage; a same-cycle pop frees the head slot so a push into a full FIFO lands safely
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wrPtr] <= write_data[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)    r_rdPtr <= r_rdPtr + PW'(1);
      if (w_accept && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_accept && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Sticky overflow flag (dropped push sets, write-1 to STATUS bit3 clears) and the baud divisor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_baud <= DEFAULT_BAUD_DIV;
    end else begin
      if (w_push && w_full && !w_pop)      r_ovf <= 1'b1;
      else if (w_statusWr && write_data[3]) r_ovf <= 1'b0;
      if (w_baudWr) r_baud <= write_data[15:0];
    end
  end

  // Transmit state register and serial datapath; reset drops any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_bcnt  <= 16'd0;
      r_bidx  <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_state <= w_nextState;
      r_tx    <= w_nextTx;
      r_bcnt  <= w_nextBcnt;
      r_bidx  <= w_nextBidx;
      r_shift <= w_nextShift;
    end
  end

`ifdef UART_PARITY_EN
  logic r_parity;

  // Even parity of the byte being sent, captured as it leaves the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^w_head;
  end
`endif

  // Next-state logic: bcnt counts down and is reloaded from the live BAUD_DIV at every bit boundary
  always_comb begin
    w_nextState = r_state;
    w_nextTx    = r_tx;
    w_nextBcnt  = r_bcnt;
    w_nextBidx  = r_bidx;
    w_nextShift = r_shift;
    w_pop       = 1'b0;
    if (r_state != S_IDLE && !w_boundary) w_nextBcnt = r_bcnt - 16'd1;
    case (r_state)
      S_IDLE: begin
        w_nextTx = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nextShift = w_head;
          w_nextTx    = 1'b0;
          w_nextBcnt  = r_baud;
          w_nextState = S_START;
        end
      end
      S_START: begin
        if (w_boundary) begin
          w_nextTx    = r_shift[0];
          w_nextBidx  = 3'd0;
          w_nextBcnt  = r_baud;
          w_nextState = S_DATA;
        end
      end
      S_DATA: begin
        if (w_boundary) begin
          w_nextBcnt = r_baud;
          if (r_bidx == 3'd7) begin
`ifdef UART_PARITY_EN
            w_nextTx    = r_parity;
            w_nextState = S_PARITY;
`else
            w_nextTx    = 1'b1;
            w_nextState = S_STOP;
`endif
          end else begin
            w_nextShift = {1'b0, r_shift[7:1]};
            w_nextTx    = r_shift[1];
            w_nextBidx  = r_bidx + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_boundary) begin
          w_nextTx    = 1'b1;
          w_nextBcnt  = r_baud;
          w_nextState = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_boundary) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nextShift = w_head;
            w_nextTx    = 1'b0;
            w_nextBcnt  = r_baud;
            w_nextState = S_START;
          end else begin
            w_nextState = S_IDLE;
          end
        end
      end
      default: begin
        w_nextTx    = 1'b1;
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Combinational register read for the load-result mux; misses and write-only/reserved offsets read 0
  always_comb begin
    read_data = '0;
    if (w_hit) begin
      case (w_off)
        2'd1:    read_data[8:0]  = {PARITY_FLAG, w_cnt4, r_ovf, (r_state != S_IDLE), w_empty, w_full};
        2'd2:    read_data[15:0] = r_baud;
        default: read_data       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register vector table plus directed serial-frame sequences.
module tb_mmio_uart_tx;

`ifdef UART_PARITY_EN
  localparam int          NBITS    = 11;
  localparam logic [31:0] PAR_FLAG = 32'h100;
`else
  localparam int          NBITS    = 10;
  localparam logic [31:0] PAR_FLAG = 32'h000;
`endif
  localparam logic [31:0] IDLE_ST = 32'h2 | PAR_FLAG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        write_en = 1'b0;
  logic [31:0] read_data;
  logic        tx;

  int vecCount = 0;
  int missCount = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] expRead;
    string       name;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
    .write_en(write_en), .read_data(read_data), .tx(tx)
  );

  // Hard bound on simulated time in case the design never settles
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    addr       = v.addr;
    write_data = v.wdata;
    write_en   = v.we;
    @(posedge clk);
    #1 write_en = 1'b0;
    #1 checkOutput(v.name, read_data, v.expRead);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    addr       = a;
    write_data = d;
    write_en   = 1'b1;
    @(posedge clk);
    #1 write_en = 1'b0;
  endtask

  task automatic readCheck(input logic [31:0] a, input logic [31:0] expected, input string name);
    addr = a;
    #1 checkOutput(name, read_data, expected);
  endtask

  // Expected line level for bit slot idx of a frame carrying data
  function automatic logic frameBit(input logic [7:0] data, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[idx-1];
    if (idx == 9 && NBITS == 11) return ^data;
    return 1'b1;
  endfunction

  // Sample tx for a number of clocks after each rising edge; one comparison per bit period
  task automatic checkBit(input logic expected, input int clocks, input string name);
    logic got;
    got = expected;
    repeat (clocks) begin
      @(posedge clk);
      #1;
      if (tx !== expected) got = tx;
    end
    checkOutput(name, {31'b0, got}, {31'b0, expected});
  endtask

  task automatic checkFrame(input logic [7:0] data, input int baud, input string name);
    for (int i = 0; i < NBITS; i++)
      checkBit(frameBit(data, i), baud + 1, $sformatf("%s_b%0d", name, i));
  endtask

  // Last clock of STOP is still busy; the following edge returns to idle
  task automatic checkFrameEnd(input string name);
    readCheck(32'h4004, 32'h6 | PAR_FLAG, {name, "_busyAtStop"});
    @(posedge clk);
    #1 readCheck(32'h4004, IDLE_ST, {name, "_idleAfter"});
  endtask

  initial begin
    vecs[0]  = '{32'h0000_4004, 32'h0,         1'b0, IDLE_ST,      "rstStatus"};
    vecs[1]  = '{32'h0000_4008, 32'h0,         1'b0, 32'h3,        "rstBaud"};
    vecs[2]  = '{32'h0000_4000, 32'h0,         1'b0, 32'h0,        "txdataReadsZero"};
    vecs[3]  = '{32'h0000_400C, 32'h0,         1'b0, 32'h0,        "reservedRead"};
    vecs[4]  = '{32'h0000_400C, 32'hFFFF_FFFF, 1'b1, 32'h0,        "reservedWrite"};
    vecs[5]  = '{32'h0000_2000, 32'h0000_0055, 1'b1, 32'h0,        "missWrite"};
    vecs[6]  = '{32'h0000_4004, 32'h0,         1'b0, IDLE_ST,      "missNoPush"};
    vecs[7]  = '{32'h0000_4008, 32'h1234_5678, 1'b1, 32'h5678,     "baudWrite"};
    vecs[8]  = '{32'h0000_400A, 32'h0,         1'b0, 32'h5678,     "lowAddrIgnored"};
    vecs[9]  = '{32'h0000_4004, 32'hFFFF_FFFF, 1'b1, IDLE_ST,      "statusReadOnly"};
    vecs[10] = '{32'h0001_4008, 32'h0,         1'b0, 32'h0,        "highMissRead"};
    vecs[11] = '{32'h0000_4008, 32'h0000_0003, 1'b1, 32'h3,        "baudRestore"};
    vecs[12] = '{32'h0001_4000, 32'h0000_0099, 1'b1, 32'h0,        "highMissWrite"};
    vecs[13] = '{32'h0000_4004, 32'h0,         1'b0, IDLE_ST,      "highMissNoPush"};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("rstTx", {31'b0, tx}, 32'h1);

    // Register-level vectors while the transmitter is idle
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Single byte 0xA5 at the default divisor
    busWrite(32'h4000, 32'hA5);
    checkOutput("latencyTxStillHigh", {31'b0, tx}, 32'h1);
    readCheck(32'h4004, 32'h10 | PAR_FLAG, "queuedOne");
    checkFrame(8'hA5, 3, "single");
    checkFrameEnd("single");

    // Six back-to-back pushes into a 4-deep FIFO: the sixth is dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          addr       = 32'h4000;
          write_data = 32'h11 * (i + 1);
          write_en   = 1'b1;
          @(posedge clk);
          #1;
        end
        write_en = 1'b0;
        addr     = 32'h4004;
        #1 checkOutput("fullStatus", read_data, 32'h4D | PAR_FLAG);
      end
      begin
        @(posedge clk);
        #1;
        for (int f = 0; f < 5; f++)
          checkFrame(8'(8'h11 * (f + 1)), 3, $sformatf("b2b%0d", f));
      end
    join
    checkBit(1'b1, 40, "noSixthFrame");
    readCheck(32'h4004, 32'hA | PAR_FLAG, "overflowSticky");
    busWrite(32'h4004, 32'h8);
    readCheck(32'h4004, IDLE_ST, "overflowCleared");

    // Minimum divisor: one clock per bit
    busWrite(32'h4008, 32'h0);
    busWrite(32'h4000, 32'hFF);
    checkFrame(8'hFF, 0, "baud0");
    checkFrameEnd("baud0");

    // Push into a full FIFO on the same edge as a pop is accepted
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          addr       = 32'h4000;
          write_data = 32'(i + 1);
          write_en   = 1'b1;
          @(posedge clk);
          #1;
        end
        write_en = 1'b0;
        repeat (NBITS - 4) @(posedge clk);
        #1;
        addr       = 32'h4000;
        write_data = 32'h06;
        write_en   = 1'b1;
        @(posedge clk);
        #1 write_en = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        for (int f = 0; f < 6; f++)
          checkFrame(8'(f + 1), 0, $sformatf("popPush%0d", f));
      end
    join
    checkBit(1'b1, 5, "popPushIdle");
    readCheck(32'h4004, IDLE_ST, "popPushNoOverflow");

    // Divisor change in the middle of DATA applies from the next bit
    busWrite(32'h4008, 32'h3);
    fork
      begin
        addr       = 32'h4000;
        write_data = 32'h3C;
        write_en   = 1'b1;
        @(posedge clk);
        #1 write_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        addr       = 32'h4008;
        write_data = 32'h7;
        write_en   = 1'b1;
        @(posedge clk);
        #1 write_en = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        checkBit(1'b0, 4, "baudChg_start");
        checkBit(frameBit(8'h3C, 1), 4, "baudChg_b1");
        for (int i = 2; i < NBITS; i++)
          checkBit(frameBit(8'h3C, i), 8, $sformatf("baudChg_b%0d", i));
      end
    join
    checkBit(1'b1, 2, "baudChgIdle");
    readCheck(32'h4008, 32'h7, "baudChgValue");

    // 0x07 exercises an odd number of ones (parity 1 when enabled)
    busWrite(32'h4008, 32'h3);
    busWrite(32'h4000, 32'h07);
    checkFrame(8'h07, 3, "byte07");
    checkFrameEnd("byte07");

    // Asynchronous reset in the middle of a data bit
    busWrite(32'h4008, 32'h5);
    busWrite(32'h4000, 32'hA5);
    repeat (15) @(posedge clk);
    #1 checkOutput("preRstTxLow", {31'b0, tx}, 32'h0);
    #2 rst_n = 1'b0;
    #1 checkOutput("rstMidFrameTx", {31'b0, tx}, 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 readCheck(32'h4004, IDLE_ST, "postRstStatus");
    readCheck(32'h4008, 32'h3, "postRstBaud");
    checkBit(1'b1, 60, "noResidualFrame");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
